cd_tx_bit_ctrl: RTL

CD_TX_BIT_CTRL -- requirements
Module: cd_tx_bit_ctrl

---
 rtl/cd_tx_bit_ctrl_pkg.sv | 24 ++
 rtl/cd_baud_rate.sv | 38 +++
 rtl/cd_tx_bit_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cd_tx_bit_ctrl_pkg.sv
// CDBUS transmit bit controller shared types.
// State encoding and stop-bit range used by the TX bit path.
package cd_tx_bit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Index of the final stop bit, clamped into the legal range.
    function automatic logic [2:0] stop_last(input int n);
        if (n <= STOP_BITS_MIN)
            return 3'd0;
        if (n >= STOP_BITS_MAX)
            return 3'(STOP_BITS_MAX - 1);
        return 3'(n - 1);
    endfunction

endpackage

// File: rtl/cd_baud_rate.sv
// CDBUS baud generator: bit-boundary strobe and 3/4 sample strobe.
// Speed is chosen per bit period by sel (0 = low, 1 = high).
module cd_baud_rate #(
    parameter bit          FOR_TX   = 1'b1,
    parameter logic [15:0] INIT_VAL = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic        sel,
    input  logic [15:0] div_ls,
    input  logic [15:0] div_hs,
    output logic        inc,
    output logic        cap
);

    logic [15:0] cnt;
    logic [15:0] div;
    logic [15:0] cap_pt;

    assign div    = sel ? div_hs : div_ls;
    assign cap_pt = div - ((div + 16'd1) >> 2);
    assign inc    = (cnt >= div);
    assign cap    = (cnt == cap_pt);

    // A receiver resyncs to mid-period; a transmitter restarts the bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= INIT_VAL;
        else if (sync)
            cnt <= FOR_TX ? INIT_VAL : (div >> 1);
        else if (inc)
            cnt <= 16'd0;
        else
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/cd_tx_bit_ctrl.sv
// CDBUS transmit bit controller: start/data/stop serialiser
// with arbitration-loss detection on the first byte of a frame.
module cd_tx_bit_ctrl
    import cd_tx_bit_ctrl_pkg::*;
#(
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] div_ls,
    input  logic [15:0] div_hs,
    input  logic [7:0]  data,
    input  logic        data_valid,
    input  logic        data_last,
    output logic        data_ready,
    input  logic        arb_en,
    input  logic        rx,
    output logic        tx,
    output logic        tx_en,
    output logic        busy,
    output logic        lost,
    output logic        done
);

    localparam logic [2:0] LAST_STOP = stop_last(STOP_BITS);

    tx_state_t   state;
    logic        sel;
    logic        sync;
    logic        inc;
    logic        cap;
    logic [2:0]  bit_cnt;
    logic [7:0]  sreg;
    logic        last_q;
    logic        arb_q;
    logic        stop_end;
    logic        chain;
    logic        accept;
    logic        arb_hit;

    cd_baud_rate #(
        .FOR_TX   (1'b1),
        .INIT_VAL (16'd0)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .sync   (sync),
        .sel    (sel),
        .div_ls (div_ls),
        .div_hs (div_hs),
        .inc    (inc),
        .cap    (cap)
    );

    // Holding sync through idle keeps the first bit a full period.
    assign sync     = (state == ST_IDLE);
    assign stop_end = (state == ST_STOP) && inc && (bit_cnt == LAST_STOP);
    assign chain    = stop_end && !last_q && data_valid;
    assign accept   = !reset &&
                      (((state == ST_IDLE) && data_valid) || chain);
    assign data_ready = accept;
    assign arb_hit  = arb_q && cap && tx && !rx &&
                      ((state == ST_START) || (state == ST_DATA));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            tx_en   <= 1'b0;
            busy    <= 1'b0;
            lost    <= 1'b0;
            done    <= 1'b0;
            sel     <= 1'b0;
            bit_cnt <= 3'd0;
            sreg    <= 8'd0;
            last_q  <= 1'b0;
            arb_q   <= 1'b0;
        end else begin
            lost <= 1'b0;
            done <= 1'b0;
            if (accept) begin
                sreg    <= data;
                last_q  <= data_last;
                arb_q   <= (state == ST_IDLE) && arb_en;
                sel     <= !((state == ST_IDLE) && arb_en);
                tx      <= 1'b0;
                tx_en   <= 1'b1;
                busy    <= 1'b1;
                bit_cnt <= 3'd0;
                state   <= ST_START;
            end else if (arb_hit) begin
                lost  <= 1'b1;
                tx    <= 1'b1;
                tx_en <= 1'b0;
                busy  <= 1'b0;
                state <= ST_IDLE;
            end else if (inc) begin
                unique case (state)
                    ST_IDLE: ;
                    ST_START: begin
                        tx    <= sreg[0];
                        state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            tx      <= 1'b1;
                            bit_cnt <= 3'd0;
                            state   <= ST_STOP;
                        end else begin
                            tx      <= sreg[1];
                            sreg    <= sreg >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ST_STOP: begin
                        if (bit_cnt == LAST_STOP) begin
                            done    <= 1'b1;
                            tx      <= 1'b1;
                            tx_en   <= 1'b0;
                            busy    <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
